// File: rtl/wm8731_pkg.sv
// Types and defaults shared by the WM8731 codec interface (ADC receiver and DAC serialiser).
package wm8731_pkg;

  localparam int unsigned AUDIO_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    WAIT
  } rx_state_t;

  typedef enum logic {
    LEFT,
    RIGHT
  } channel_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchroniser for a codec pin, with registered level and edge strobes.
module pin_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  // level acts as the history flop, so the strobes stay aligned with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], pin};
      level <= sync[STAGES-1];
      rise  <= sync[STAGES-1] & ~level;
      fall  <= ~sync[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/wm8731_adc_rx.sv
// I2S capture receiver for the WM8731 ADC: deserialises left/right words and
// hands each complete stereo pair to the system clock domain via valid/ready.
module wm8731_adc_rx
  import wm8731_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = AUDIO_W,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    AUD_BCLK,
  input  logic                    AUD_ADCLRCK,
  input  logic                    AUD_ADCDAT,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  output logic                    frame_err,
  input  logic                    clear_flags
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH);

  logic bclk_rise, bclk_level_unused, bclk_fall_unused;
  logic lrck_level, lrck_rise, lrck_fall, lrck_edge;
  logic [SYNC_STAGES:0] dat_pipe;
  logic data_s;

  rx_state_t state, state_next;
  channel_t  chan;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-2:0] shreg;
  logic [SAMPLE_WIDTH-1:0] left_hold, word;
  logic pair_ok;
  logic start_half, short_frame, shift_en, last_bit, commit, accept;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (AUD_BCLK),
    .level (bclk_level_unused),
    .rise  (bclk_rise),
    .fall  (bclk_fall_unused)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (AUD_ADCLRCK),
    .level (lrck_level),
    .rise  (lrck_rise),
    .fall  (lrck_fall)
  );

  // One extra flop matches the registered strobe latency of pin_sync_edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dat_pipe <= '0;
    else       dat_pipe <= {dat_pipe[SYNC_STAGES-1:0], AUD_ADCDAT};
  end

  assign data_s    = dat_pipe[SYNC_STAGES];
  assign lrck_edge = lrck_rise | lrck_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_half  = 1'b0;
    short_frame = 1'b0;
    shift_en    = 1'b0;
    last_bit    = 1'b0;
    case (state)
      IDLE: if (lrck_fall) begin
        state_next = DELAY;
        start_half = 1'b1;
      end
      DELAY: begin
        if (lrck_edge) begin
          short_frame = 1'b1;
          start_half  = 1'b1;
        end else if (bclk_rise) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (lrck_edge) begin
          short_frame = 1'b1;
          start_half  = 1'b1;
          state_next  = DELAY;
        end else if (bclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(SAMPLE_WIDTH - 1)) begin
            last_bit   = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: if (lrck_edge) begin
        state_next = DELAY;
        start_half = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    word   = {shreg, data_s};
    commit = last_bit && (chan == RIGHT) && pair_ok;
    accept = sample_valid && sample_ready;
  end

  // A left half always opens a fresh pair; a short left word poisons the pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan      <= LEFT;
      bit_cnt   <= '0;
      shreg     <= '0;
      left_hold <= '0;
      pair_ok   <= 1'b0;
    end else if (start_half) begin
      chan    <= lrck_level ? RIGHT : LEFT;
      bit_cnt <= '0;
      pair_ok <= lrck_fall | (pair_ok & ~short_frame);
    end else if (shift_en) begin
      shreg   <= word[SAMPLE_WIDTH-2:0];
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      if (last_bit && chan == LEFT) left_hold <= word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (commit && (!sample_valid || sample_ready)) begin
        sample_left  <= left_hold;
        sample_right <= word;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
      if (commit && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clear_flags)                        overrun <= 1'b0;
      if (short_frame)      frame_err <= 1'b1;
      else if (clear_flags) frame_err <= 1'b0;
    end
  end

endmodule
